// File: rtl/periph_pkg.sv
`default_nettype none
// ============================================================================
// Module      : periph_pkg
// Description : Shared constants for the peripheral bus unit: register
//               byte offsets inside the 32-byte window, TCON bit positions,
//               UART frame length and the transmitter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package periph_pkg;

    // Byte offsets of the mapped words, relative to BASE_ADDR
    localparam logic [4:0] OFF_TH   = 5'h00;
    localparam logic [4:0] OFF_TL   = 5'h04;
    localparam logic [4:0] OFF_TCON = 5'h08;
    localparam logic [4:0] OFF_LED  = 5'h0C;
    localparam logic [4:0] OFF_SW   = 5'h10;
    localparam logic [4:0] OFF_DIGI = 5'h14;
    localparam logic [4:0] OFF_UTXD = 5'h18;
    localparam logic [4:0] OFF_UCON = 5'h1C;

    // TCON bit positions
    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    // Start bit + 8 data bits + stop bit
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_core
// Description : 8N1 serial transmitter. A start strobe while idle latches
//               the byte; the frame (start, 8 data LSB first, stop) is sent
//               with every bit held BAUD_DIV cycles.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   start      in   begin a frame (ignored while busy)
//   data       in   byte to send, sampled with start
//   txd        out  serial line, idle high (registered)
//   busy       out  frame in progress
//   done_pulse out  high in the last cycle of the stop bit, i.e. on the
//                   same edge that drops busy
// ============================================================================
module uart_tx_core
    import periph_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy,
    output logic       done_pulse
);

    localparam int              C_CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [C_CW-1:0] C_BAUD_LAST = C_CW'(BAUD_DIV - 1);
    localparam logic [C_CW-1:0] C_BAUD_ONE  = C_CW'(1);
    localparam logic [3:0]      C_BIT_LAST  = 4'(UART_FRAME_BITS - 1);
    // Bit index 8 is the last data bit; moving past it enters the stop bit
    localparam logic [3:0]      C_DATA_LAST = 4'd8;

    tx_state_t       r_state;
    logic [C_CW-1:0] r_baud_cnt;
    logic [3:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_txd;

    logic w_baud_tick;
    logic w_frame_end;

    assign w_baud_tick = (r_state == TX_SEND) && (r_baud_cnt == C_BAUD_LAST);
    assign w_frame_end = w_baud_tick && (r_bit_cnt == C_BIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= TX_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (start) begin
                        r_state    <= TX_SEND;
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_shift    <= data;
                        r_txd      <= 1'b0;     // start bit
                    end
                end
                TX_SEND: begin
                    if (w_baud_tick) begin
                        r_baud_cnt <= '0;
                        if (w_frame_end) begin
                            r_state <= TX_IDLE;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt < C_DATA_LAST) begin
                                r_txd   <= r_shift[0];
                                r_shift <= {1'b0, r_shift[7:1]};
                            end else begin
                                r_txd   <= 1'b1;    // stop bit
                            end
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + C_BAUD_ONE;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign txd        = r_txd;
    assign busy       = (r_state == TX_SEND);
    assign done_pulse = w_frame_end;

endmodule
`default_nettype wire

// File: rtl/periph_bus_unit.sv
`default_nettype none
// ============================================================================
// Module      : periph_bus_unit
// Description : Memory-mapped peripheral slave for the single-cycle core.
//               32-byte window at BASE_ADDR holding a reloadable timer with
//               interrupt, LED and seven-segment output registers, a switch
//               input and an optional UART transmitter.
//               Optional feature macro: PERIPH_UART_TX_EN (UART transmitter;
//               when undefined uart_txd is tied high and the UART words
//               read 0).
// Revision    : 1.0 - initial release
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   rd        in   read strobe
//   wr        in   write strobe
//   addr      in   byte address, addr[1:0] ignored
//   wdata     in   write data
//   rdata     out  read data, combinational, 0 unless a mapped word is read
//   irqout    out  timer interrupt request
//   led       out  LED register
//   switch    in   board switches
//   digi      out  seven-segment register ([11:8] anodes, [7:0] segments)
//   uart_txd  out  serial transmit line, idle high
// ============================================================================
module periph_bus_unit
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8,
    parameter int          BAUD_DIV  = 5208
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd,
    input  logic             wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irqout,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  switch,
    output logic [11:0]      digi,
    output logic             uart_txd
);

    logic             w_hit;
    logic [4:0]       w_off;
    logic             w_we_th, w_we_tl, w_we_tcon, w_we_led, w_we_digi;
    logic             w_tl_max;
    logic             w_ovf;
    logic [31:0]      w_ucon;
    logic [31:0]      w_rdata;

    logic [31:0]      r_th;
    logic [31:0]      r_tl;
    logic [2:0]       r_tcon;
    logic [LED_W-1:0] r_led;
    logic [11:0]      r_digi;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_hit     = (addr[31:5] == BASE_ADDR[31:5]);
    assign w_off     = {addr[4:2], 2'b00};

    assign w_we_th   = wr & w_hit & (w_off == OFF_TH);
    assign w_we_tl   = wr & w_hit & (w_off == OFF_TL);
    assign w_we_tcon = wr & w_hit & (w_off == OFF_TCON);
    assign w_we_led  = wr & w_hit & (w_off == OFF_LED);
    assign w_we_digi = wr & w_hit & (w_off == OFF_DIGI);

    // ------------------------------------------------------------------
    // Timer. An overflow only takes effect when the CPU is not writing
    // TL or TCON in the same cycle; the CPU write takes priority.
    // ------------------------------------------------------------------
    assign w_tl_max = (r_tl == 32'hFFFF_FFFF);
    assign w_ovf    = r_tcon[TCON_EN] & w_tl_max & ~w_we_tl & ~w_we_tcon;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th   <= '0;
            r_tl   <= '0;
            r_tcon <= '0;
            r_led  <= '0;
            r_digi <= '0;
        end else begin
            // A TH write in the overflow cycle still reloads the old TH,
            // because the reload below reads r_th before this edge.
            if (w_we_th) begin
                r_th <= wdata;
            end

            if (w_we_tl) begin
                r_tl <= wdata;
            end else if (r_tcon[TCON_EN]) begin
                if (!w_tl_max) begin
                    r_tl <= r_tl + 32'd1;
                end else if (w_ovf) begin
                    r_tl <= r_th;
                end
            end

            if (w_we_tcon) begin
                r_tcon <= wdata[2:0];
            end else if (w_ovf && r_tcon[TCON_IE]) begin
                r_tcon[TCON_IS] <= 1'b1;
            end

            if (w_we_led) begin
                r_led <= wdata[LED_W-1:0];
            end

            if (w_we_digi) begin
                r_digi <= wdata[11:0];
            end
        end
    end

    assign irqout = r_tcon[TCON_IE] & r_tcon[TCON_IS];
    assign led    = r_led;
    assign digi   = r_digi;

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
`ifdef PERIPH_UART_TX_EN
    logic w_tx_start;
    logic w_tx_busy;
    logic w_tx_done;
    logic w_rd_ucon;
    logic r_tx_done;
    logic w_unused;

    // Writes while a frame is in flight are dropped here
    assign w_tx_start = wr & w_hit & (w_off == OFF_UTXD) & ~w_tx_busy;
    assign w_rd_ucon  = rd & w_hit & (w_off == OFF_UCON);

    uart_tx_core #(
        .BAUD_DIV   (BAUD_DIV)
    ) u_uart_tx_core (
        .clk        (clk),
        .reset      (reset),
        .start      (w_tx_start),
        .data       (wdata[7:0]),
        .txd        (uart_txd),
        .busy       (w_tx_busy),
        .done_pulse (w_tx_done)
    );

    // Sticky completion flag; a finishing frame wins over a clearing read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_done <= 1'b0;
        end else if (w_tx_done) begin
            r_tx_done <= 1'b1;
        end else if (w_rd_ucon) begin
            r_tx_done <= 1'b0;
        end
    end

    assign w_ucon   = {30'd0, r_tx_done, w_tx_busy};
    assign w_unused = ^addr[1:0];
`else
    logic w_unused;

    assign uart_txd = 1'b1;
    assign w_ucon   = '0;
    assign w_unused = ^{addr[1:0], BAUD_DIV[0]};
`endif

    // ------------------------------------------------------------------
    // Read mux (zero latency)
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (rd && w_hit) begin
            case (w_off)
                OFF_TH:   w_rdata = r_th;
                OFF_TL:   w_rdata = r_tl;
                OFF_TCON: w_rdata = {29'd0, r_tcon};
                OFF_LED:  w_rdata = 32'(r_led);
                OFF_SW:   w_rdata = 32'(switch);
                OFF_DIGI: w_rdata = {20'd0, r_digi};
                OFF_UCON: w_rdata = w_ucon;
                default:  w_rdata = '0;   // UART_TXD is write-only
            endcase
        end
    end

    assign rdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_periph_bus_unit
// Description : Scoreboard bench for periph_bus_unit. The driver issues bus
//               operations and pushes the expected read data; a negedge
//               monitor pops and compares reads and checks the output pins
//               against a behavioural model of the register map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_bus_unit;

    localparam int          BAUD = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef PERIPH_UART_TX_EN
    localparam bit UART_EN = 1'b1;
`else
    localparam bit UART_EN = 1'b0;
`endif

    localparam logic [31:0] A_TH   = BASE + 32'h00;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_LED  = BASE + 32'h0C;
    localparam logic [31:0] A_SW   = BASE + 32'h10;
    localparam logic [31:0] A_DIGI = BASE + 32'h14;
    localparam logic [31:0] A_UTXD = BASE + 32'h18;
    localparam logic [31:0] A_UCON = BASE + 32'h1C;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        irqout;
    logic [7:0]  led, sw;
    logic [11:0] digi;
    logic        uart_txd;

    always #10 clk = ~clk;

    periph_bus_unit #(
        .BASE_ADDR (BASE),
        .LED_W     (8),
        .SW_W      (8),
        .BAUD_DIV  (BAUD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irqout   (irqout),
        .led      (led),
        .switch   (sw),
        .digi     (digi),
        .uart_txd (uart_txd)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    // ---------------- behavioural model ----------------
    logic [31:0] m_th, m_tl;
    bit          m_en, m_ie, m_is;
    logic [7:0]  m_led;
    logic [11:0] m_digi;
    bit          m_busy, m_done;
    int          m_elapsed;
    logic [7:0]  m_byte;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_th = 0; m_tl = 0; m_en = 0; m_ie = 0; m_is = 0;
        m_led = 0; m_digi = 0;
        m_busy = 0; m_done = 0; m_elapsed = 0; m_byte = 0;
    endfunction

    function automatic bit in_window(logic [31:0] a);
        return (a >> 5) == (BASE >> 5);
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        int idx;
        if (!in_window(a)) return 32'd0;
        idx = int'(a[4:2]);
        case (idx)
            0: return m_th;
            1: return m_tl;
            2: return {29'd0, m_is, m_ie, m_en};
            3: return {24'd0, m_led};
            4: return {24'd0, sw};
            5: return {20'd0, m_digi};
            7: return UART_EN ? {30'd0, m_done, m_busy} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Model of one clock edge with the given bus operation
    function automatic void model_step(bit r, bit w, logic [31:0] a, logic [31:0] d);
        bit hit = in_window(a);
        int idx = int'(a[4:2]);
        bit wtl = w && hit && idx == 1;
        bit wtc = w && hit && idx == 2;
        bit fin = 0;
        if (m_en) begin
            if (m_tl != 32'hFFFF_FFFF) m_tl = m_tl + 1;
            else if (!wtl && !wtc) begin
                m_tl = m_th;
                if (m_ie) m_is = 1;
            end
        end
        if (UART_EN) begin
            if (m_busy) begin
                m_elapsed++;
                if (m_elapsed == 10 * BAUD) begin m_busy = 0; fin = 1; end
            end else if (w && hit && idx == 6) begin
                m_busy = 1; m_elapsed = 0; m_byte = d[7:0];
            end
            if (r && hit && idx == 7) m_done = 0;
            if (fin) m_done = 1;
        end
        if (w && hit) begin
            case (idx)
                0: m_th = d;
                1: m_tl = d;
                2: {m_is, m_ie, m_en} = d[2:0];
                3: m_led = d[7:0];
                5: m_digi = d[11:0];
                default: ;
            endcase
        end
    endfunction

    function automatic logic exp_txd();
        int b;
        if (!UART_EN || !m_busy) return 1'b1;
        b = m_elapsed / BAUD;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (rd) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata: read with empty scoreboard, got %h expected none", rdata);
                end else begin
                    check(name_q.pop_front(), rdata, exp_q.pop_front());
                end
            end
            check("irqout", 32'(irqout), 32'(m_ie & m_is));
            check("led", 32'(led), 32'(m_led));
            check("digi", 32'(digi), 32'(m_digi));
            check("uart_txd", 32'(uart_txd), 32'(exp_txd()));
        end
    end

    // ---------------- driver ----------------
    task automatic bus_op(input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input string nm);
        rd = r; wr = w; addr = a; wdata = d;
        if (r) begin
            exp_q.push_back(model_read(a));
            name_q.push_back(nm);
        end
        @(posedge clk);
        model_step(r, w, a, d);
        #1;
        rd = 0; wr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_op(0, 0, 32'd0, 32'd0, "idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; rd = 0; wr = 0; addr = 0; wdata = 0; sw = 8'hA5;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_irq", 32'(irqout), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_digi", 32'(digi), 32'd0);
        reset = 1;
        idle(1);

        // Read every offset after reset
        for (int k = 0; k < 8; k++) bus_op(1, 0, BASE + 32'(k * 4), 32'd0, "reset_read");

        // Timer reload and interrupt
        bus_op(0, 1, A_TH, 32'hFFFF_FFFC, "");
        bus_op(0, 1, A_TL, 32'hFFFF_FFFE, "");
        bus_op(0, 1, A_TCON, 32'h3, "");
        for (int k = 0; k < 4; k++) bus_op(1, 0, A_TL, 32'd0, "tl_run");
        bus_op(1, 0, A_TCON, 32'd0, "tcon_irq");
        bus_op(0, 1, A_TCON, 32'h3, "");
        bus_op(1, 0, A_TCON, 32'd0, "tcon_ack");

        // TL write in the overflow cycle
        bus_op(0, 1, A_TCON, 32'h0, "");
        bus_op(0, 1, A_TL, 32'hFFFF_FFFD, "");
        bus_op(0, 1, A_TCON, 32'h3, "");
        idle(2);
        bus_op(0, 1, A_TL, 32'h10, "");
        bus_op(1, 0, A_TL, 32'd0, "tl_wr_ovf");
        bus_op(1, 0, A_TCON, 32'd0, "tcon_wr_ovf");

        // TCON write in the overflow cycle
        bus_op(0, 1, A_TL, 32'hFFFF_FFFE, "");
        idle(1);
        bus_op(0, 1, A_TCON, 32'h3, "");
        bus_op(1, 0, A_TL, 32'd0, "tl_tcon_ovf");
        bus_op(1, 0, A_TCON, 32'd0, "tcon_tcon_ovf");

        // TH write in the overflow cycle: reload uses the old TH
        bus_op(0, 1, A_TL, 32'hFFFF_FFFE, "");
        idle(1);
        bus_op(0, 1, A_TH, 32'h0000_1234, "");
        bus_op(1, 0, A_TL, 32'd0, "tl_th_ovf");
        bus_op(1, 0, A_TH, 32'd0, "th_th_ovf");
        bus_op(1, 0, A_TCON, 32'd0, "tcon_th_ovf");

        // Disable freezes TL, status retained
        bus_op(0, 1, A_TCON, 32'h6, "");
        bus_op(1, 0, A_TL, 32'd0, "tl_frozen_a");
        bus_op(1, 0, A_TL, 32'd0, "tl_frozen_b");
        bus_op(1, 0, A_TCON, 32'd0, "tcon_frozen");
        bus_op(0, 1, A_TCON, 32'h0, "");

        // LED / DIGI / out-of-window / read-only
        bus_op(0, 1, A_LED, 32'h1FF, "");
        bus_op(0, 1, A_DIGI, 32'hF3C0, "");
        bus_op(0, 1, BASE + 32'h20, 32'hDEAD_BEEF, "");
        bus_op(1, 0, BASE + 32'h20, 32'd0, "outside_read");
        bus_op(0, 1, A_SW, 32'h1234_5678, "");
        bus_op(1, 0, A_SW, 32'd0, "switch_read");
        bus_op(1, 0, A_LED, 32'd0, "led_read");
        bus_op(1, 0, A_DIGI, 32'd0, "digi_read");
        bus_op(1, 0, A_UTXD, 32'd0, "utxd_read");

        // UART frame
        bus_op(0, 1, A_UTXD, 32'h55, "");
        idle(14);
        bus_op(0, 1, A_UTXD, 32'hAA, "");
        bus_op(1, 0, A_UCON, 32'd0, "ucon_busy");
        for (int i = 0; i < 100 && m_busy; i++) idle(1);
        bus_op(1, 0, A_UCON, 32'd0, "ucon_done");
        bus_op(1, 0, A_UCON, 32'd0, "ucon_cleared");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            int          k;
            bit          r, w;
            k = $urandom_range(0, 15);
            if (k == 15) a = $urandom;
            else a = BASE | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            r = 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 31) == 0) sw = 8'($urandom);
            bus_op(r, w, a, $urandom, "rand_read");
        end

        // Reset in the middle of a frame with the timer running
        for (int i = 0; i < 100 && m_busy; i++) idle(1);
        bus_op(0, 1, A_TL, 32'h5, "");
        bus_op(0, 1, A_TCON, 32'h1, "");
        bus_op(0, 1, A_UTXD, 32'h3C, "");
        idle(14);
        #1 reset = 0;
        #1 check("midrst_txd", 32'(uart_txd), 32'd1);
        rd = 1; addr = A_UCON;
        #1 check("midrst_ucon", rdata, 32'd0);
        addr = A_TL;
        #1 check("midrst_tl", rdata, 32'd0);
        rd = 0; addr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1;
        idle(60);
        bus_op(1, 0, A_TL, 32'd0, "post_rst_tl");
        bus_op(1, 0, A_UCON, 32'd0, "post_rst_ucon");
        idle(2);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
